imm_share_arbiter: RTL and testbench
====================================

Name: imm_share_arbiter

Overview:
- Shares one combinational immediate-extend unit between the two decode lanes of the dual-issue front end.
- Each lane presents an instruction word with a valid/ready handshake.
- Each cycle the block grants at most one lane, routes that lane's instruction to the shared extender and registers the returned immediate into the granted lane's one-entry response buffer.
- The buffered immediate is returned to the lane with its own valid/ready handshake, plus a flag for unsupported opcodes.

Parameters:
- XLEN, 32, width of instruction word and immediate.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- req0_valid  input  1  lane 0 instruction valid
- req0_instr  input  XLEN  lane 0 instruction word
- req0_ready  output  1  lane 0 request accepted this cycle
- req1_valid  input  1  lane 1 instruction valid
- req1_instr  input  XLEN  lane 1 instruction word
- req1_ready  output  1  lane 1 request accepted this cycle
- ext_instr  output  XLEN  instruction driven to the shared extender
- ext_imm  input  XLEN  extender result, combinational from ext_instr
- rsp0_valid  output  1  lane 0 immediate valid
- rsp0_imm  output  XLEN  lane 0 immediate
- rsp0_illegal  output  1  lane 0 opcode not supported by extender
- rsp0_ready  input  1  lane 0 consumer accepts response
- rsp1_valid / rsp1_imm / rsp1_illegal / rsp1_ready: same as lane 0, for lane 1

Behaviour:
- **Reset**
  - Asynchronous; takes effect immediately, mid-transaction included.
  - Clears both response buffers: rspN_valid=0, rspN_imm=0, rspN_illegal=0.
  - Sets last_grant=1, so lane 0 has priority on the first contested cycle.
  - reqN_ready=0 while rst is high; in-flight responses are discarded.
- **Per-lane buffer**
  - One entry per lane; states EMPTY and FULL, with rspN_valid = FULL.
  - FULL→EMPTY when rspN_valid & rspN_ready and no new grant to that lane in the same cycle.
  - EMPTY→FULL on a grant.
  - FULL stays FULL with new data when a grant and a drain occur in the same cycle (pass-through, no bubble).
- **Eligibility**
  - Lane N is eligible when reqN_valid & (buffer EMPTY | (rspN_valid & rspN_ready)).
- **Arbitration (round-robin)**
  - One eligible lane: it is granted.
  - Both eligible: grant the lane != last_grant.
  - last_grant updates only on a grant. No grant leaves it unchanged.
- **Request handshake**
  - reqN_ready = grant to lane N, combinational in the same cycle.
  - A transfer occurs on reqN_valid & reqN_ready.
  - A non-granted lane must hold its request; the block never drops a valid request.
- **Extender routing**
  - ext_instr = granted lane's instruction.
  - With no grant, ext_instr = 32'h00000013 (ADDI x0,x0,0) so the extender never sees X.
- **Latency**
  - A request accepted in cycle N gives rspN_valid=1 from cycle N+1.
  - rspN_imm is ext_imm sampled at the end of cycle N.
  - Sustained throughput is one immediate per cycle total across both lanes.
- **Illegal flag**
  - Registered alongside the immediate.
  - Set when instr[6:0] is not one of: 0000011, 0100011, 1101111, 1100111, 1100011, 0110111, 0010011, 0010111.
  - When set, rspN_imm = 0; ext_imm is ignored.
- **Stability**
  - While rspN_valid & !rspN_ready, rspN_imm and rspN_illegal hold constant.
- **Starvation bound**
  - With both lanes continuously eligible, grants strictly alternate 0,1,0,1...

Test Plan:
- Reset, then req0_valid=1 with req0_instr=32'hFFC00093 (addi x1,x0,-4), rsp0_ready=1 → req0_ready=1 in cycle 0; rsp0_valid=1, rsp0_imm=32'hFFFFFFFC, rsp0_illegal=0 in cycle 1.
- Both lanes valid every cycle, both rsp_ready=1 → grants alternate 0,1,0,1 with lane 0 first; each lane gets rspN_valid every other cycle.
- Lane 1 holds rsp1_ready=0 with its buffer FULL, lane 1 valid, lane 0 idle → req1_ready=0 and ext_instr=32'h00000013; rsp1_imm stays stable. Raising rsp1_ready grants lane 1 in that same cycle.
- req0_instr=32'h0000007F (unsupported opcode) → rsp0_illegal=1, rsp0_imm=0 one cycle later.
- Assert rst while both buffers are FULL and both requests are valid → all rsp_valid drop to 0 immediately. After release, lane 0 wins the first contested cycle.
- Back-to-back on lane 0 with rsp0_ready=1: lui 32'h123450B7, then slli 32'h00509093 → imm 32'h12345000, then 32'h00000005, on consecutive cycles with no bubble.

Source files
------------

// File: rtl/imm_share_arbiter_if.sv
// Bundle between the two decode lanes, the shared immediate extender and
// imm_share_arbiter.
//   req0/req1 : lane instruction requests (valid/instr in, ready out)
//   rsp0/rsp1 : buffered immediate responses (valid/imm/illegal out, ready in)
//   ext_*     : shared combinational extender (instr out, imm back)
// slave  = the arbiter's view; master = the lanes/extender side.
interface imm_share_arbiter_if #(
    parameter int XLEN = 32
);
    logic            req0_valid;
    logic [XLEN-1:0] req0_instr;
    logic            req0_ready;
    logic            req1_valid;
    logic [XLEN-1:0] req1_instr;
    logic            req1_ready;
    logic [XLEN-1:0] ext_instr;
    logic [XLEN-1:0] ext_imm;
    logic            rsp0_valid;
    logic [XLEN-1:0] rsp0_imm;
    logic            rsp0_illegal;
    logic            rsp0_ready;
    logic            rsp1_valid;
    logic [XLEN-1:0] rsp1_imm;
    logic            rsp1_illegal;
    logic            rsp1_ready;

    modport slave (
        input  req0_valid, req0_instr, req1_valid, req1_instr,
        output req0_ready, req1_ready,
        output ext_instr,
        input  ext_imm,
        output rsp0_valid, rsp0_imm, rsp0_illegal,
        output rsp1_valid, rsp1_imm, rsp1_illegal,
        input  rsp0_ready, rsp1_ready
    );

    modport master (
        output req0_valid, req0_instr, req1_valid, req1_instr,
        input  req0_ready, req1_ready,
        input  ext_instr,
        output ext_imm,
        input  rsp0_valid, rsp0_imm, rsp0_illegal,
        input  rsp1_valid, rsp1_imm, rsp1_illegal,
        output rsp0_ready, rsp1_ready
    );
endinterface

// File: rtl/imm_share_arbiter.sv
// imm_share_arbiter: shares one combinational immediate extender between two
// decode lanes. At most one lane is granted per cycle (round-robin when both
// are eligible); the granted lane's instruction is driven to the extender and
// the result lands in that lane's one-entry response buffer next cycle.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - imm_share_arbiter_if.slave (lane requests, responses, extender)
module imm_share_arbiter #(
    parameter int XLEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    imm_share_arbiter_if.slave  bus
);
    localparam logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} buf_state_e;

    buf_state_e      state_q [2];
    buf_state_e      state_d [2];
    logic [XLEN-1:0] imm_q   [2];
    logic [XLEN-1:0] imm_d   [2];
    logic            ill_q   [2];
    logic            ill_d   [2];
    logic            last_grant_q, last_grant_d;

    logic [1:0]      req_v, rsp_rdy, elig, gnt;
    logic [XLEN-1:0] req_instr [2];
    logic            new_ill;
    logic [XLEN-1:0] new_imm;

    function automatic logic opcode_illegal(input logic [6:0] op);
        case (op)
            7'b0000011, 7'b0100011, 7'b1101111, 7'b1100111,
            7'b1100011, 7'b0110111, 7'b0010011, 7'b0010111: return 1'b0;
            default:                                         return 1'b1;
        endcase
    endfunction

    assign req_v        = {bus.req1_valid, bus.req0_valid};
    assign rsp_rdy      = {bus.rsp1_ready, bus.rsp0_ready};
    assign req_instr[0] = bus.req0_instr;
    assign req_instr[1] = bus.req1_instr;

    // A FULL buffer that drains this cycle can take a new entry in the same
    // cycle, so back-to-back requests see no bubble.
    always_comb begin
        for (int i = 0; i < 2; i++)
            elig[i] = req_v[i] & ((state_q[i] == EMPTY) | rsp_rdy[i]);
    end

    // last_grant_q names the lane that won most recently; on a tie the other
    // lane wins. Reset value 1 gives lane 0 the first contested cycle.
    assign gnt[0] = elig[0] & (~elig[1] | last_grant_q);
    assign gnt[1] = elig[1] & (~elig[0] | ~last_grant_q);

    // Ready is forced low while reset is held, even though the registers are
    // already cleared, so no request is accepted into a discarded state.
    assign bus.req0_ready = gnt[0] & ~rst;
    assign bus.req1_ready = gnt[1] & ~rst;

    // Without a grant the extender gets a harmless ADDI x0,x0,0 instead of X.
    assign bus.ext_instr = gnt[0] ? req_instr[0] :
                           gnt[1] ? req_instr[1] : NOP_INSTR;

    assign new_ill = opcode_illegal(bus.ext_instr[6:0]);
    assign new_imm = new_ill ? '0 : bus.ext_imm;

    always_comb begin
        last_grant_d = last_grant_q;
        if (gnt[1])      last_grant_d = 1'b1;
        else if (gnt[0]) last_grant_d = 1'b0;

        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            imm_d[i]   = imm_q[i];
            ill_d[i]   = ill_q[i];
            case (state_q[i])
                EMPTY: begin
                    if (gnt[i]) begin
                        state_d[i] = FULL;
                        imm_d[i]   = new_imm;
                        ill_d[i]   = new_ill;
                    end
                end
                FULL: begin
                    // Grant wins over drain: refill in place (pass-through).
                    if (gnt[i]) begin
                        imm_d[i] = new_imm;
                        ill_d[i] = new_ill;
                    end else if (rsp_rdy[i]) begin
                        state_d[i] = EMPTY;
                    end
                end
                default: state_d[i] = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= 1'b1;
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= EMPTY;
                imm_q[i]   <= '0;
                ill_q[i]   <= 1'b0;
            end
        end else begin
            last_grant_q <= last_grant_d;
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= state_d[i];
                imm_q[i]   <= imm_d[i];
                ill_q[i]   <= ill_d[i];
            end
        end
    end

    assign bus.rsp0_valid   = (state_q[0] == FULL);
    assign bus.rsp0_imm     = imm_q[0];
    assign bus.rsp0_illegal = ill_q[0];
    assign bus.rsp1_valid   = (state_q[1] == FULL);
    assign bus.rsp1_imm     = imm_q[1];
    assign bus.rsp1_illegal = ill_q[1];
endmodule

// File: tb/tb_imm_share_arbiter.sv
// Self-checking bench for imm_share_arbiter: a directed vector table, a few
// hand-written multi-cycle sequences (async reset) and a randomized phase
// checked against a per-lane one-entry mailbox model.
module tb_imm_share_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    imm_share_arbiter_if #(.XLEN(32)) bus ();

    imm_share_arbiter #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Lane-side stimulus
    logic        rv [2];
    logic [31:0] ri [2];
    logic        sr [2];

    assign bus.req0_valid = rv[0];
    assign bus.req0_instr = ri[0];
    assign bus.req1_valid = rv[1];
    assign bus.req1_instr = ri[1];
    assign bus.rsp0_ready = sr[0];
    assign bus.rsp1_ready = sr[1];

    // Behavioural RV32 immediate extender; unknown opcodes return garbage
    // that the DUT must mask to zero.
    function automatic logic [31:0] ext_model(input logic [31:0] i);
        case (i[6:0])
            7'b0000011, 7'b1100111, 7'b0010011: return {{20{i[31]}}, i[31:20]};
            7'b0100011: return {{20{i[31]}}, i[31:25], i[11:7]};
            7'b1100011: return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            7'b0110111, 7'b0010111: return {i[31:12], 12'h000};
            7'b1101111: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    assign bus.ext_imm = ext_model(bus.ext_instr);

    function automatic logic is_legal(input logic [6:0] op);
        return op inside {7'b0000011, 7'b0100011, 7'b1101111, 7'b1100111,
                          7'b1100011, 7'b0110111, 7'b0010011, 7'b0010111};
    endfunction

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each lane owns a one-slot mailbox; winner picked by
    // round-robin over the lanes that can accept this cycle.
    logic        m_full [2];
    logic [31:0] m_imm  [2];
    logic        m_ill  [2];
    int          m_last;

    task automatic model_reset();
        m_last = 1;
        for (int i = 0; i < 2; i++) begin
            m_full[i] = 1'b0;
            m_imm[i]  = 32'h0;
            m_ill[i]  = 1'b0;
        end
    endtask

    // Called at a negedge with inputs already set; checks, clocks, updates.
    task automatic step(input string tag);
        logic [1:0]  el;
        int          win;
        logic [31:0] exp_ext;
        #1;
        for (int i = 0; i < 2; i++) el[i] = rv[i] && (!m_full[i] || sr[i]);
        if (el == 2'b11)  win = 1 - m_last;
        else if (el[0])   win = 0;
        else if (el[1])   win = 1;
        else              win = -1;
        exp_ext = (win < 0) ? 32'h0000_0013 : ri[win];
        chk({tag, " req0_ready"}, 32'(bus.req0_ready), 32'(win == 0));
        chk({tag, " req1_ready"}, 32'(bus.req1_ready), 32'(win == 1));
        chk({tag, " ext_instr"},  bus.ext_instr, exp_ext);
        chk({tag, " rsp0_valid"}, 32'(bus.rsp0_valid), 32'(m_full[0]));
        chk({tag, " rsp1_valid"}, 32'(bus.rsp1_valid), 32'(m_full[1]));
        if (m_full[0]) begin
            chk({tag, " rsp0_imm"},     bus.rsp0_imm, m_imm[0]);
            chk({tag, " rsp0_illegal"}, 32'(bus.rsp0_illegal), 32'(m_ill[0]));
        end
        if (m_full[1]) begin
            chk({tag, " rsp1_imm"},     bus.rsp1_imm, m_imm[1]);
            chk({tag, " rsp1_illegal"}, 32'(bus.rsp1_illegal), 32'(m_ill[1]));
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (m_full[i] && sr[i]) m_full[i] = 1'b0;
            if (win == i) begin
                m_full[i] = 1'b1;
                m_ill[i]  = !is_legal(ri[i][6:0]);
                m_imm[i]  = m_ill[i] ? 32'h0 : ext_model(ri[i]);
            end
        end
        if (win >= 0) m_last = win;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rv[i] = 1'b0; ri[i] = 32'h0; sr[i] = 1'b0;
        end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("reset rsp0_valid", 32'(bus.rsp0_valid), 32'h0);
        chk("reset rsp1_valid", 32'(bus.rsp1_valid), 32'h0);
        chk("reset rsp0_imm",   bus.rsp0_imm, 32'h0);
        chk("reset rsp1_imm",   bus.rsp1_imm, 32'h0);
        rst = 1'b0;
    endtask

    typedef struct {
        logic        r0v; logic [31:0] r0i;
        logic        r1v; logic [31:0] r1i;
        logic        s0r; logic        s1r;
        logic        x_rdy0; logic x_rdy1; logic [31:0] x_ext;
        logic        x_v0; logic [31:0] x_imm0; logic x_ill0;
        logic        x_v1; logic [31:0] x_imm1; logic x_ill1;
    } vec_t;

    vec_t tbl [14];
    logic pend [2];
    int   r;
    logic [6:0] ops [9];

    initial begin
        // Directed sequence from reset; expected outputs sampled before each edge.
        tbl[0]  = '{1, 32'hFFC00093, 0, 32'h0,        1, 1, 1, 0, 32'hFFC00093, 0, 32'h0,        0, 0, 32'h0,        0};
        tbl[1]  = '{0, 32'h0,        0, 32'h0,        1, 1, 0, 0, 32'h00000013, 1, 32'hFFFFFFFC, 0, 0, 32'h0,        0};
        tbl[2]  = '{1, 32'h0000007F, 0, 32'h0,        1, 1, 1, 0, 32'h0000007F, 0, 32'h0,        0, 0, 32'h0,        0};
        tbl[3]  = '{1, 32'h123450B7, 0, 32'h0,        1, 1, 1, 0, 32'h123450B7, 1, 32'h0,        1, 0, 32'h0,        0};
        tbl[4]  = '{1, 32'h00509093, 0, 32'h0,        1, 1, 1, 0, 32'h00509093, 1, 32'h12345000, 0, 0, 32'h0,        0};
        tbl[5]  = '{0, 32'h0,        0, 32'h0,        1, 1, 0, 0, 32'h00000013, 1, 32'h00000005, 0, 0, 32'h0,        0};
        tbl[6]  = '{0, 32'h0,        1, 32'hFFC00093, 1, 0, 0, 1, 32'hFFC00093, 0, 32'h0,        0, 0, 32'h0,        0};
        tbl[7]  = '{0, 32'h0,        1, 32'h00100113, 1, 0, 0, 0, 32'h00000013, 0, 32'h0,        0, 1, 32'hFFFFFFFC, 0};
        tbl[8]  = '{0, 32'h0,        1, 32'h00100113, 1, 0, 0, 0, 32'h00000013, 0, 32'h0,        0, 1, 32'hFFFFFFFC, 0};
        tbl[9]  = '{0, 32'h0,        1, 32'h00100113, 1, 1, 0, 1, 32'h00100113, 0, 32'h0,        0, 1, 32'hFFFFFFFC, 0};
        tbl[10] = '{0, 32'h0,        0, 32'h0,        1, 1, 0, 0, 32'h00000013, 0, 32'h0,        0, 1, 32'h00000001, 0};
        tbl[11] = '{1, 32'h00100113, 1, 32'h00200113, 1, 1, 1, 0, 32'h00100113, 0, 32'h0,        0, 0, 32'h0,        0};
        tbl[12] = '{1, 32'h00100113, 1, 32'h00200113, 1, 1, 0, 1, 32'h00200113, 1, 32'h00000001, 0, 0, 32'h0,        0};
        tbl[13] = '{1, 32'h00100113, 1, 32'h00200113, 1, 1, 1, 0, 32'h00100113, 0, 32'h0,        0, 1, 32'h00000002, 0};

        ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b1101111;
        ops[3] = 7'b1100111; ops[4] = 7'b1100011; ops[5] = 7'b0110111;
        ops[6] = 7'b0010011; ops[7] = 7'b0010111; ops[8] = 7'b1111111;

        @(negedge clk);
        do_reset();

        // Phase 1: vector table
        for (int k = 0; k < 14; k++) begin
            rv[0] = tbl[k].r0v; ri[0] = tbl[k].r0i;
            rv[1] = tbl[k].r1v; ri[1] = tbl[k].r1i;
            sr[0] = tbl[k].s0r; sr[1] = tbl[k].s1r;
            #1;
            chk($sformatf("vec%0d req0_ready", k), 32'(bus.req0_ready), 32'(tbl[k].x_rdy0));
            chk($sformatf("vec%0d req1_ready", k), 32'(bus.req1_ready), 32'(tbl[k].x_rdy1));
            chk($sformatf("vec%0d ext_instr", k),  bus.ext_instr, tbl[k].x_ext);
            chk($sformatf("vec%0d rsp0_valid", k), 32'(bus.rsp0_valid), 32'(tbl[k].x_v0));
            chk($sformatf("vec%0d rsp1_valid", k), 32'(bus.rsp1_valid), 32'(tbl[k].x_v1));
            if (tbl[k].x_v0) begin
                chk($sformatf("vec%0d rsp0_imm", k), bus.rsp0_imm, tbl[k].x_imm0);
                chk($sformatf("vec%0d rsp0_illegal", k), 32'(bus.rsp0_illegal), 32'(tbl[k].x_ill0));
            end
            if (tbl[k].x_v1) begin
                chk($sformatf("vec%0d rsp1_imm", k), bus.rsp1_imm, tbl[k].x_imm1);
                chk($sformatf("vec%0d rsp1_illegal", k), 32'(bus.rsp1_illegal), 32'(tbl[k].x_ill1));
            end
            @(negedge clk);
        end

        // Phase 2: async reset with both buffers FULL and both requests valid.
        do_reset();
        rv[0] = 1; ri[0] = 32'h00300113; rv[1] = 1; ri[1] = 32'h00400113;
        sr[0] = 0; sr[1] = 0;
        step("fill");     // lane 0 wins (last_grant reset to 1)
        step("fill");     // lane 1 wins
        sr[0] = 1;
        step("fill");     // lane 0 pass-through; last grant now lane 0
        sr[0] = 0;
        step("hold");     // both FULL, stalled
        #2 rst = 1'b1;
        #1;
        chk("async rst rsp0_valid", 32'(bus.rsp0_valid), 32'h0);
        chk("async rst rsp1_valid", 32'(bus.rsp1_valid), 32'h0);
        chk("async rst rsp0_imm",   bus.rsp0_imm, 32'h0);
        chk("async rst rsp1_illegal", 32'(bus.rsp1_illegal), 32'h0);
        chk("async rst req0_ready", 32'(bus.req0_ready), 32'h0);
        chk("async rst req1_ready", 32'(bus.req1_ready), 32'h0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        sr[0] = 1; sr[1] = 1;
        #1;
        chk("post rst lane0 first", 32'(bus.req0_ready), 32'h1);
        #(-1ps + 1ps);
        step("post rst");
        step("post rst alt");

        // Phase 3: randomized traffic; a non-accepted request is held.
        do_reset();
        pend[0] = 0; pend[1] = 0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i]) begin
                    rv[i] = ($urandom_range(0, 9) < 7);
                    r     = $urandom_range(0, 8);
                    ri[i] = {$urandom()} & 32'hFFFF_FF80;
                    ri[i][6:0] = ops[r];
                end
                sr[i] = ($urandom_range(0, 9) < 6);
            end
            #1;
            pend[0] = rv[0] && !bus.req0_ready;
            pend[1] = rv[1] && !bus.req1_ready;
            #(-1ps + 1ps);
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
